gyro_spi_responder: RTL and testbench



---
 rtl/gyro_pkg.sv | 39 +++
 rtl/spi_pin_sync.sv | 40 ++++
 rtl/gyro_spi_responder.sv | 136 +++++++++++++
 tb/tb_gyro_spi_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gyro_pkg.sv
// Register map, command-byte fields and FSM states of the L3G4200D-style gyro SPI interface,
// shared by the emulated responder and the gyro master FSM.
package gyro_pkg;

    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;
    localparam logic [5:0] ADDR_OUT_X_H  = 6'h29;
    localparam logic [5:0] ADDR_OUT_Y_L  = 6'h2A;
    localparam logic [5:0] ADDR_OUT_Y_H  = 6'h2B;
    localparam logic [5:0] ADDR_OUT_Z_L  = 6'h2C;
    localparam logic [5:0] ADDR_OUT_Z_H  = 6'h2D;

    localparam int RW_BIT = 7;
    localparam int MS_BIT = 6;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} spi_state_t;

    // snap packs {dz, dy, dx}; unmapped addresses read as zero
    function automatic logic [7:0] reg_read(input logic [5:0]  addr,
                                            input logic [47:0] snap,
                                            input logic [7:0]  ctrl1,
                                            input logic [7:0]  who_am_i);
        logic [7:0] v;
        case (addr)
            ADDR_WHO_AM_I: v = who_am_i;
            ADDR_CTRL1:    v = ctrl1;
            ADDR_OUT_X_L:  v = snap[7:0];
            ADDR_OUT_X_H:  v = snap[15:8];
            ADDR_OUT_Y_L:  v = snap[23:16];
            ADDR_OUT_Y_H:  v = snap[31:24];
            ADDR_OUT_Z_L:  v = snap[39:32];
            ADDR_OUT_Z_H:  v = snap[47:40];
            default:       v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer with registered rise/fall flags for one asynchronous pin; idles high.
// Flags pulse one CLK, STAGES+1 CLK after the pin edge; o_lvl is aligned with the flags.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    logic              w_s;

    assign w_s = r_sync[STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= '1;
            r_prev <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= w_s;
            r_rise <= w_s & ~r_prev;
            r_fall <= ~w_s & r_prev;
        end
    end

    assign o_lvl  = r_prev;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/gyro_spi_responder.sv
// Mode-3 SPI slave emulating the gyro register file; serves a dx/dy/dz snapshot taken at CS fall.
// MISO follows SCLK falls by SYNC_STAGES+2 CLK; no backpressure, SCLK phases must be >= 4 CLK.
module gyro_spi_responder
    import gyro_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
    parameter logic [7:0] CTRL1_RST    = 8'h07
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] dx,
    input  logic [15:0] dy,
    input  logic [15:0] dz,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [7:0]  ctrl_reg1,
    output logic        busy
);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .CLK(CLK), .RST(RST), .i_pin(sclk),
        .o_lvl(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .CLK(CLK), .RST(RST), .i_pin(cs_n),
        .o_lvl(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .CLK(CLK), .RST(RST), .i_pin(mosi),
        .o_lvl(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

    assign w_unused = &{1'b0, w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};

    spi_state_t  r_state, w_state_nxt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_rx;
    logic [7:0]  r_tx;
    logic [5:0]  r_addr;
    logic        r_rw;
    logic        r_ms;
    logic [47:0] r_snap;
    logic [7:0]  r_ctrl1;
    logic        r_miso;
    logic        r_oe;

    logic [7:0]  w_rx_byte;
    logic        w_byte_done;
    logic [5:0]  w_addr_nxt;

    assign w_rx_byte   = {r_rx[6:0], w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_addr_nxt  = r_ms ? r_addr + 6'd1 : r_addr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_nxt = ADDR;
            ADDR:    if (w_byte_done) w_state_nxt = DATA;
            default: w_state_nxt = r_state;
        endcase
        // CS release outranks any SCLK edge seen in the same cycle
        if (w_cs_rise) w_state_nxt = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_rx      <= 8'h00;
            r_tx      <= 8'h00;
            r_addr    <= 6'h00;
            r_rw      <= 1'b0;
            r_ms      <= 1'b0;
            r_snap    <= 48'h0;
            r_ctrl1   <= CTRL1_RST;
            r_miso    <= 1'b1;
            r_oe      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cs_rise) begin
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b1;
                r_oe      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (w_cs_fall) begin
                        r_bit_cnt <= 3'd0;
                        r_snap    <= {dz, dy, dx};
                        r_oe      <= 1'b1;
                    end
                    ADDR: if (w_sclk_rise) begin
                        r_rx      <= w_rx_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_byte_done) begin
                            r_rw   <= w_rx_byte[RW_BIT];
                            r_ms   <= w_rx_byte[MS_BIT];
                            r_addr <= w_rx_byte[5:0];
                            if (w_rx_byte[RW_BIT])
                                r_tx <= reg_read(w_rx_byte[5:0], r_snap, r_ctrl1, WHO_AM_I_VAL);
                        end
                    end
                    DATA: begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_byte_done) begin
                                if (!r_rw && r_addr == ADDR_CTRL1)
                                    r_ctrl1 <= w_rx_byte;
                                r_addr <= w_addr_nxt;
                                if (r_rw)
                                    r_tx <= reg_read(w_addr_nxt, r_snap, r_ctrl1, WHO_AM_I_VAL);
                            end
                        end else if (w_sclk_fall && r_rw) begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                    end
                    default: r_bit_cnt <= 3'd0;
                endcase
            end
        end
    end

    assign miso      = r_miso;
    assign miso_oe   = r_oe;
    assign ctrl_reg1 = r_ctrl1;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_gyro_spi_responder.sv
// Drives mode-3 SPI transactions into gyro_spi_responder and checks them against a register-map model.
module tb_gyro_spi_responder;

    localparam int         HALF  = 8;
    localparam int         SYNC  = 2;
    localparam logic [7:0] WHO   = 8'hD3;
    localparam logic [7:0] CRST  = 8'h07;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] dx, dy, dz;
    logic        sclk, cs_n, mosi;
    logic        miso, miso_oe, busy;
    logic [7:0]  ctrl_reg1;

    always #5 CLK = ~CLK;

    gyro_spi_responder #(.SYNC_STAGES(SYNC), .WHO_AM_I_VAL(WHO), .CTRL1_RST(CRST)) dut (
        .CLK(CLK), .RST(RST), .dx(dx), .dy(dy), .dz(dz),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .ctrl_reg1(ctrl_reg1), .busy(busy));

    int tests_run = 0;
    int fails     = 0;

    logic [7:0]  tx_buf [0:15];
    logic [7:0]  rx_buf [0:15];
    logic        oe_drop;
    int          oe_off;
    int          chg_byte = -1;
    logic [15:0] chg_val;

    // model: CTRL_REG1 contents and the snapshot the slave should hold
    logic [7:0]  m_ctrl;
    logic [47:0] m_snap;

    function automatic logic [7:0] m_reg(input logic [5:0] a);
        if (a == 6'h0F) return WHO;
        if (a == 6'h20) return m_ctrl;
        if (a >= 6'h28 && a <= 6'h2D) return m_snap[(int'(a) - 'h28) * 8 +: 8];
        return 8'h00;
    endfunction

    task automatic spi_begin;
        oe_drop = 1'b0;
        m_snap  = {dz, dy, dx};
        cs_n    = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic spi_bit(input int b);
        int idx = b / 8;
        int bt  = 7 - (b % 8);
        sclk = 1'b0;
        mosi = tx_buf[idx][bt];
        repeat (HALF) @(negedge CLK);
        if (idx > 0) rx_buf[idx][bt] = miso;
        if (!miso_oe) oe_drop = 1'b1;
        sclk = 1'b1;
        repeat (HALF) @(negedge CLK);
        if ((b % 8) == 7 && idx == chg_byte) dx = chg_val;
    endtask

    task automatic spi_end;
        repeat (4) @(negedge CLK);
        cs_n   = 1'b1;
        oe_off = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (!miso_oe && oe_off < 0) oe_off = k + 1;
        end
    endtask

    task automatic spi_xfer(input int nbits);
        spi_begin();
        for (int b = 0; b < nbits; b++) spi_bit(b);
        spi_end();
    endtask

    task automatic test_reset;
        RST = 1'b1; sclk = 1'b1; cs_n = 1'b1; mosi = 1'b1;
        dx = 16'h0; dy = 16'h0; dz = 16'h0;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        m_ctrl = CRST;
        @(negedge CLK);
        tests_run++;
        if ({miso, miso_oe, busy, ctrl_reg1} !== {1'b1, 1'b0, 1'b0, CRST}) begin
            fails++;
            $display("FAIL reset: miso/oe/busy/ctrl=%b/%b/%b/%h required 1/0/0/%h",
                     miso, miso_oe, busy, ctrl_reg1, CRST);
        end
    endtask

    task automatic test_who_am_i;
        tx_buf[0] = 8'h8F;
        spi_xfer(16);
        tests_run++;
        if (rx_buf[1] !== WHO) begin
            fails++; $display("FAIL who_am_i: got %h required %h", rx_buf[1], WHO);
        end
        tests_run++;
        if (oe_drop !== 1'b0) begin
            fails++; $display("FAIL oe_during_cs: miso_oe dropped while CS low, required held 1");
        end
        tests_run++;
        if (oe_off < 1 || oe_off > SYNC + 3) begin
            fails++; $display("FAIL oe_release: miso_oe low after %0d CLK, required 1..%0d", oe_off, SYNC + 3);
        end
    endtask

    task automatic test_burst;
        logic [7:0] exp [0:5];
        exp = '{8'h34, 8'h12, 8'hCE, 8'hFF, 8'h01, 8'h00};
        dx = 16'h1234; dy = 16'hFFCE; dz = 16'h0001;
        tx_buf[0] = 8'hE8;
        spi_xfer(56);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (rx_buf[i + 1] !== exp[i]) begin
                fails++; $display("FAIL burst byte %0d: got %h required %h", i, rx_buf[i + 1], exp[i]);
            end
        end
    endtask

    task automatic test_snapshot_coherent;
        dx = 16'h1234;
        chg_byte = 1; chg_val = 16'hAAAA;
        tx_buf[0] = 8'hE8;
        spi_xfer(32);
        chg_byte = -1;
        tests_run++;
        if ({rx_buf[1], rx_buf[2]} !== 16'h3412) begin
            fails++; $display("FAIL snapshot_hold: got %h %h required 34 12", rx_buf[1], rx_buf[2]);
        end
        spi_xfer(24);
        tests_run++;
        if ({rx_buf[1], rx_buf[2]} !== 16'hAAAA) begin
            fails++; $display("FAIL snapshot_next: got %h %h required aa aa", rx_buf[1], rx_buf[2]);
        end
    endtask

    task automatic test_abort_and_wrap;
        tx_buf[0] = 8'h20; tx_buf[1] = 8'h55;
        spi_xfer(13);
        tests_run++;
        if (ctrl_reg1 !== CRST || busy !== 1'b0) begin
            fails++; $display("FAIL partial_write: ctrl=%h busy=%b required %h 0", ctrl_reg1, busy, CRST);
        end
        tx_buf[0] = 8'hFF;
        rx_buf[1] = 8'hXX; rx_buf[2] = 8'hXX;
        spi_xfer(24);
        tests_run++;
        if ({rx_buf[1], rx_buf[2]} !== 16'h0000) begin
            fails++; $display("FAIL addr_wrap: got %h %h required 00 00", rx_buf[1], rx_buf[2]);
        end
    endtask

    task automatic test_write;
        tx_buf[0] = 8'h20; tx_buf[1] = 8'h0F;
        spi_xfer(16);
        m_ctrl = 8'h0F;
        tests_run++;
        if (ctrl_reg1 !== 8'h0F) begin
            fails++; $display("FAIL write_ctrl1: got %h required 0f", ctrl_reg1);
        end
        tx_buf[0] = 8'hA0;
        spi_xfer(16);
        tests_run++;
        if (rx_buf[1] !== 8'h0F) begin
            fails++; $display("FAIL readback_ctrl1: got %h required 0f", rx_buf[1]);
        end
        tx_buf[0] = 8'h21; tx_buf[1] = 8'h55;
        spi_xfer(16);
        tests_run++;
        if (ctrl_reg1 !== 8'h0F) begin
            fails++; $display("FAIL write_other: ctrl=%h required 0f", ctrl_reg1);
        end
    endtask

    task automatic test_reset_mid;
        tx_buf[0] = 8'hA8; tx_buf[1] = 8'h00;
        spi_begin();
        for (int b = 0; b < 11; b++) spi_bit(b);
        RST = 1'b1;
        @(negedge CLK);
        m_ctrl = CRST;
        tests_run++;
        if ({miso_oe, busy, ctrl_reg1} !== {1'b0, 1'b0, CRST}) begin
            fails++; $display("FAIL reset_mid: oe/busy/ctrl=%b/%b/%h required 0/0/%h",
                              miso_oe, busy, ctrl_reg1, CRST);
        end
        cs_n = 1'b1; sclk = 1'b1;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        tx_buf[0] = 8'h8F;
        spi_xfer(16);
        tests_run++;
        if (rx_buf[1] !== WHO) begin
            fails++; $display("FAIL who_after_reset: got %h required %h", rx_buf[1], WHO);
        end
    endtask

    task automatic test_random;
        logic [5:0] picks [0:7];
        logic [5:0] base, a;
        logic       rw, ms;
        int         nb;
        picks = '{6'h0F, 6'h20, 6'h28, 6'h2A, 6'h2C, 6'h2D, 6'h3F, 6'h1F};
        for (int n = 0; n < 24; n++) begin
            dx = 16'($urandom); dy = 16'($urandom); dz = 16'($urandom);
            rw = 1'($urandom_range(0, 3) != 0);
            ms = 1'($urandom_range(0, 1));
            base = ($urandom_range(0, 3) == 0) ? 6'($urandom) : picks[$urandom_range(0, 7)];
            nb = $urandom_range(1, 4);
            tx_buf[0] = {rw, ms, base};
            for (int i = 1; i <= nb; i++) tx_buf[i] = 8'($urandom);
            spi_xfer(8 * (nb + 1));
            for (int i = 1; i <= nb; i++) begin
                a = ms ? 6'(base + 6'(i - 1)) : base;
                if (rw) begin
                    tests_run++;
                    if (rx_buf[i] !== m_reg(a)) begin
                        fails++; $display("FAIL rand_read n=%0d addr=%h: got %h required %h",
                                          n, a, rx_buf[i], m_reg(a));
                    end
                end else if (a == 6'h20) begin
                    m_ctrl = tx_buf[i];
                end
            end
            tests_run++;
            if (ctrl_reg1 !== m_ctrl || busy !== 1'b0) begin
                fails++; $display("FAIL rand_ctrl n=%0d: ctrl=%h busy=%b required %h 0",
                                  n, ctrl_reg1, busy, m_ctrl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_who_am_i();
        test_burst();
        test_snapshot_coherent();
        test_abort_and_wrap();
        test_write();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
